// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// No logic of its own; zero latency.
// No flow control here; users own their handshakes.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADJ_THRESH = 4'd5;
    localparam bcd_digit_t ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_adjust_shift.sv
// One double-dabble step: add-3 to every digit >= 5, then shift {scratch, shift_reg} left by one.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module bcd_adjust_shift
    import bin2bcd_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int N_DIGITS = 8
) (
    input  logic [4*N_DIGITS-1:0] scratch,
    input  logic [DATA_W-1:0]     shift_reg,
    output logic [4*N_DIGITS-1:0] scratch_nxt,
    output logic [DATA_W-1:0]     shift_nxt,
    output logic                  carry
);

    logic [4*N_DIGITS-1:0] adj;

    // A digit is at most 9 before adjust, so the 4-bit sum never exceeds 12.
    always_comb begin
        bcd_digit_t d;
        adj = '0;
        d   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = scratch[4*i +: 4];
            adj[4*i +: 4] = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;
        end
    end

    // The bit leaving the top digit is worth 10^N_DIGITS and marks overflow.
    assign {carry, scratch_nxt, shift_nxt} = {adj, shift_reg, 1'b0};

endmodule

// File: rtl/bin2bcd_seq.sv
// Converts a DATA_W-bit value to N_DIGITS packed BCD digits, one double-dabble step per clock.
// Latency: done pulses DATA_W cycles after the accepting edge; one conversion per DATA_W+1 cycles.
// in_ready is low while converting; offered values are not queued and must be held or re-issued.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int N_DIGITS = 8,
    parameter int SIGNED   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  neg,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  shift_nxt;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_nxt;
    logic               carry;
    logic               sign_pend;
    logic               ovf_pend;
    logic               in_neg;
    logic [DATA_W-1:0]  in_mag;

    // Negating the most negative value wraps to 2^(DATA_W-1) as an unsigned magnitude.
    assign in_neg   = (SIGNED != 0) && in_data[DATA_W-1];
    assign in_mag   = in_neg ? -in_data : in_data;
    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT);

    bcd_adjust_shift #(
        .DATA_W   (DATA_W),
        .N_DIGITS (N_DIGITS)
    ) u_step (
        .scratch     (scratch),
        .shift_reg   (shift_reg),
        .scratch_nxt (scratch_nxt),
        .shift_nxt   (shift_nxt),
        .carry       (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_reg <= '0;
            scratch   <= '0;
            sign_pend <= 1'b0;
            ovf_pend  <= 1'b0;
            bcd_out   <= '0;
            neg       <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_mag;
                        sign_pend <= in_neg;
                        scratch   <= '0;
                        ovf_pend  <= 1'b0;
                        cnt       <= CNT_W'(DATA_W);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_nxt;
                    shift_reg <= shift_nxt;
                    ovf_pend  <= ovf_pend | carry;
                    cnt       <= cnt - CNT_W'(1);
                    // Publish straight from the step output so no extra DONE cycle is needed.
                    if (cnt == CNT_W'(1)) begin
                        bcd_out  <= scratch_nxt;
                        neg      <= sign_pend;
                        overflow <= ovf_pend | carry;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
